cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 38 +++
 rtl/cdb_arbiter_rr_pick2.sv | 53 +++++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared types and constants for the common-data-bus arbiter.
//                Holds the bus entry layout, requester index names and the
//                default requester count.
//  Revision    : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int C_NREQ_DEFAULT = 4;
    localparam int C_DATA_W       = 32;
    localparam int C_REG_W        = 6;

    // Requester index of each execution unit
    typedef enum logic [1:0] {
        UNIT_BRANCH = 2'd0,
        UNIT_ALU    = 2'd1,
        UNIT_LS     = 2'd2,
        UNIT_MUL    = 2'd3
    } unit_e;

    // One registered common-data-bus slot
    typedef struct packed {
        logic                valid;
        logic                tag;
        logic [C_REG_W-1:0]  arn;
        logic [C_REG_W-1:0]  rrn;
        logic [C_DATA_W-1:0] data;
    } cdb_entry_t;

    // Width of an index into an n-entry vector (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at ptr and wrapping, returning the first and second
//                set positions found.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ  = C_NREQ_DEFAULT,
    parameter int PTR_W = idx_width(NREQ)
)
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] first_idx,
    output logic [PTR_W-1:0] second_idx,
    output logic             first_found,
    output logic             second_found
);

    localparam logic [PTR_W:0] C_NREQ = (PTR_W+1)'(NREQ);

    logic [PTR_W:0] w_pos;

    // Walk the ring from ptr, latching the first two requesting positions
    always_comb begin
        first_idx    = '0;
        second_idx   = '0;
        first_found  = 1'b0;
        second_found = 1'b0;
        w_pos        = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_pos >= C_NREQ) begin
                w_pos = w_pos - C_NREQ;
            end
            if (req[w_pos[PTR_W-1:0]]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = w_pos[PTR_W-1:0];
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = w_pos[PTR_W-1:0];
                end
            end
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Grants up to two execution-unit results per cycle onto two
//                registered common data buses in round-robin order, skipping
//                tagged results while a speculative flush is active.
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ   = C_NREQ_DEFAULT,
    parameter int DATA_W = C_DATA_W,
    parameter int REG_W  = C_REG_W
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        delete_tagged,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             req_tag,
    input  logic [NREQ-1:0][REG_W-1:0]  req_arn,
    input  logic [NREQ-1:0][REG_W-1:0]  req_rrn,
    input  logic [NREQ-1:0][DATA_W-1:0] req_data,
    output logic [NREQ-1:0]             grant,
    output logic                        bus1_valid,
    output logic                        bus1_tag,
    output logic [REG_W-1:0]            bus1_arn,
    output logic [REG_W-1:0]            bus1_rrn,
    output logic [DATA_W-1:0]           bus1_data,
    output logic                        bus2_valid,
    output logic                        bus2_tag,
    output logic [REG_W-1:0]            bus2_arn,
    output logic [REG_W-1:0]            bus2_rrn,
    output logic [DATA_W-1:0]           bus2_data
);

    localparam int                 C_PTR_W    = idx_width(NREQ);
    localparam logic [C_PTR_W-1:0] C_LAST_IDX = C_PTR_W'(NREQ-1);

    // Bus slots use the package entry layout, so the widths must agree
    generate
        if (DATA_W != C_DATA_W || REG_W != C_REG_W) begin : g_width_guard
            $error("cdb_arbiter: DATA_W/REG_W must match cdb_arbiter_pkg widths");
        end
    endgenerate

    logic [C_PTR_W-1:0] r_ptr;
    cdb_entry_t         r_bus1;
    cdb_entry_t         r_bus2;

    logic [NREQ-1:0]    w_elig;
    logic [C_PTR_W-1:0] w_first_idx;
    logic [C_PTR_W-1:0] w_second_idx;
    logic               w_first_found;
    logic               w_second_found;
    logic [C_PTR_W-1:0] w_last_idx;
    logic [C_PTR_W-1:0] w_ptr_nxt;
    cdb_entry_t         w_bus1_nxt;
    cdb_entry_t         w_bus2_nxt;

    // Tagged requests drop out of arbitration while a flush is signalled
    assign w_elig = req & ~({NREQ{delete_tagged}} & req_tag);

    rr_pick2 #(
        .NREQ  (NREQ),
        .PTR_W (C_PTR_W)
    ) u_pick (
        .req          (w_elig),
        .ptr          (r_ptr),
        .first_idx    (w_first_idx),
        .second_idx   (w_second_idx),
        .first_found  (w_first_found),
        .second_found (w_second_found)
    );

    // Grants are suppressed during reset so no requester believes it was accepted
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (w_first_found) begin
                grant[w_first_idx] = 1'b1;
            end
            if (w_second_found) begin
                grant[w_second_idx] = 1'b1;
            end
        end
    end

    // Next pointer sits just past the last unit granted in scan order
    always_comb begin
        w_last_idx = w_second_found ? w_second_idx : w_first_idx;
        w_ptr_nxt  = (w_last_idx == C_LAST_IDX) ? '0 : w_last_idx + C_PTR_W'(1);
    end

    // Capture granted payloads; an unused slot stays all-zero so rrn reads as 0
    always_comb begin
        w_bus1_nxt = '0;
        w_bus2_nxt = '0;
        if (w_first_found) begin
            w_bus1_nxt.valid = 1'b1;
            w_bus1_nxt.tag   = req_tag[w_first_idx];
            w_bus1_nxt.arn   = req_arn[w_first_idx];
            w_bus1_nxt.rrn   = req_rrn[w_first_idx];
            w_bus1_nxt.data  = req_data[w_first_idx];
        end
        if (w_second_found) begin
            w_bus2_nxt.valid = 1'b1;
            w_bus2_nxt.tag   = req_tag[w_second_idx];
            w_bus2_nxt.arn   = req_arn[w_second_idx];
            w_bus2_nxt.rrn   = req_rrn[w_second_idx];
            w_bus2_nxt.data  = req_data[w_second_idx];
        end
    end

    // Pointer and bus registers; reset discards any entry in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_bus1 <= '0;
            r_bus2 <= '0;
        end else begin
            r_bus1 <= w_bus1_nxt;
            r_bus2 <= w_bus2_nxt;
            if (w_first_found) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus1_valid = r_bus1.valid;
    assign bus1_tag   = r_bus1.tag;
    assign bus1_arn   = r_bus1.arn;
    assign bus1_rrn   = r_bus1.rrn;
    assign bus1_data  = r_bus1.data;
    assign bus2_valid = r_bus2.valid;
    assign bus2_tag   = r_bus2.tag;
    assign bus2_arn   = r_bus2.arn;
    assign bus2_rrn   = r_bus2.rrn;
    assign bus2_data  = r_bus2.data;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter: directed scenarios plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int REG_W  = 6;
    localparam int ENT_W  = 2 + 2*REG_W + DATA_W;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        delete_tagged;
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             req_tag;
    logic [NREQ-1:0][REG_W-1:0]  req_arn;
    logic [NREQ-1:0][REG_W-1:0]  req_rrn;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0]             grant;
    logic                        bus1_valid, bus1_tag, bus2_valid, bus2_tag;
    logic [REG_W-1:0]            bus1_arn, bus1_rrn, bus2_arn, bus2_rrn;
    logic [DATA_W-1:0]           bus1_data, bus2_data;

    logic [ENT_W-1:0] dut_bus1;
    logic [ENT_W-1:0] dut_bus2;
    assign dut_bus1 = {bus1_valid, bus1_tag, bus1_arn, bus1_rrn, bus1_data};
    assign dut_bus2 = {bus2_valid, bus2_tag, bus2_arn, bus2_rrn, bus2_data};

    int tests = 0;
    int fails = 0;

    // Reference model state
    int               m_ptr = 0;
    int               e_ptr = 0;
    logic [NREQ-1:0]  e_grant;
    logic [ENT_W-1:0] e_bus [2];

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .delete_tagged (delete_tagged),
        .req           (req),
        .req_tag       (req_tag),
        .req_arn       (req_arn),
        .req_rrn       (req_rrn),
        .req_data      (req_data),
        .grant         (grant),
        .bus1_valid    (bus1_valid),
        .bus1_tag      (bus1_tag),
        .bus1_arn      (bus1_arn),
        .bus1_rrn      (bus1_rrn),
        .bus1_data     (bus1_data),
        .bus2_valid    (bus2_valid),
        .bus2_tag      (bus2_tag),
        .bus2_arn      (bus2_arn),
        .bus2_rrn      (bus2_rrn),
        .bus2_data     (bus2_data)
    );

    // Model: list eligible units in ring order from ptr, accept the first two
    task automatic model_eval();
        int order[$];
        int i;
        e_grant  = '0;
        e_bus[0] = '0;
        e_bus[1] = '0;
        e_ptr    = m_ptr;
        if (reset) begin
            e_ptr = 0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (req[i] && !(delete_tagged && req_tag[i])) order.push_back(i);
            end
            for (int b = 0; b < 2 && b < order.size(); b++) begin
                i = order[b];
                e_grant[i] = 1'b1;
                e_bus[b]   = {1'b1, req_tag[i], req_arn[i], req_rrn[i], req_data[i]};
                e_ptr      = (i + 1) % NREQ;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_ptr = e_ptr;
        #1;
    endtask

    task automatic rand_payload(input int i);
        req_arn[i]  = REG_W'($urandom);
        req_rrn[i]  = REG_W'($urandom);
        req_data[i] = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        #1;
        model_eval();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; req_tag = '0; delete_tagged = 1'b0;
        for (int i = 0; i < NREQ; i++) rand_payload(i);
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0000) begin
            fails++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000);
        end
        tick();
        tests++;
        if (dut_bus1 !== '0 || dut_bus2 !== '0) begin
            fails++; $display("FAIL reset_bus_idle: bus1=%h bus2=%h expected 0", dut_bus1, dut_bus2);
        end
        reset = 1'b0;
    endtask

    task automatic test_all_req();
        logic [NREQ-1:0] pat [3];
        pat[0] = 4'b0011; pat[1] = 4'b1100; pat[2] = 4'b0011;
        req = 4'b1111; req_tag = '0; delete_tagged = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NREQ; i++) rand_payload(i);
            #1;
            model_eval();
            tests++;
            if (grant !== pat[c]) begin
                fails++; $display("FAIL all_req_grant[%0d]: got %b expected %b", c, grant, pat[c]);
            end
            tick();
            tests++;
            if (dut_bus1 !== e_bus[0] || dut_bus2 !== e_bus[1]) begin
                fails++; $display("FAIL all_req_bus[%0d]: got %h/%h expected %h/%h",
                                  c, dut_bus1, dut_bus2, e_bus[0], e_bus[1]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; req_tag = '0; delete_tagged = 1'b0;
        rand_payload(2);
        req_rrn[2] = 6'h21; req_data[2] = 32'hDEADBEEF;
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0100) begin
            fails++; $display("FAIL single_grant: got %b expected %b", grant, 4'b0100);
        end
        tick();
        tests++;
        if (bus1_valid !== 1'b1 || bus1_rrn !== 6'h21 || bus1_data !== 32'hDEADBEEF || dut_bus1 !== e_bus[0]) begin
            fails++; $display("FAIL single_bus1: got %h expected %h", dut_bus1, e_bus[0]);
        end
        tests++;
        if (dut_bus2 !== '0) begin
            fails++; $display("FAIL single_bus2_idle: got %h expected 0", dut_bus2);
        end
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) rand_payload(i);
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b1001) begin
            fails++; $display("FAIL single_ptr3: got %b expected %b", grant, 4'b1001);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100; req_tag = '0; delete_tagged = 1'b0;
        rand_payload(2);
        #1; model_eval(); tick();
        req = 4'b1001;
        rand_payload(0); rand_payload(3);
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b1001) begin
            fails++; $display("FAIL wrap_grant: got %b expected %b", grant, 4'b1001);
        end
        tick();
        tests++;
        if (bus1_rrn !== req_rrn[3] || bus2_rrn !== req_rrn[0] || bus2_data !== req_data[0]
            || dut_bus1 !== e_bus[0] || dut_bus2 !== e_bus[1]) begin
            fails++; $display("FAIL wrap_bus: got %h/%h expected %h/%h", dut_bus1, dut_bus2, e_bus[0], e_bus[1]);
        end
        req = 4'b1111;
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0110) begin
            fails++; $display("FAIL wrap_ptr1: got %b expected %b", grant, 4'b0110);
        end
        tick();
    endtask

    task automatic test_delete_tagged();
        do_reset();
        req = 4'b0011; req_tag = 4'b0001; delete_tagged = 1'b1;
        rand_payload(0); rand_payload(1);
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0010) begin
            fails++; $display("FAIL delete_grant: got %b expected %b", grant, 4'b0010);
        end
        tick();
        tests++;
        if (bus1_rrn !== req_rrn[1] || bus1_tag !== 1'b0 || dut_bus1 !== e_bus[0] || dut_bus2 !== '0) begin
            fails++; $display("FAIL delete_bus: got %h/%h expected %h/0", dut_bus1, dut_bus2, e_bus[0]);
        end
        req = 4'b0001; delete_tagged = 1'b0;
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0001) begin
            fails++; $display("FAIL delete_release: got %b expected %b", grant, 4'b0001);
        end
        tick();
        tests++;
        if (bus1_tag !== 1'b1 || dut_bus1 !== e_bus[0]) begin
            fails++; $display("FAIL delete_release_bus: got %h expected %h", dut_bus1, e_bus[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111; req_tag = '0; delete_tagged = 1'b0;
        for (int i = 0; i < NREQ; i++) rand_payload(i);
        #1; model_eval(); tick();
        reset = 1'b1; delete_tagged = 1'b1;
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0000) begin
            fails++; $display("FAIL midreset_grant: got %b expected %b", grant, 4'b0000);
        end
        tick();
        tests++;
        if (dut_bus1 !== '0 || dut_bus2 !== '0) begin
            fails++; $display("FAIL midreset_bus: got %h/%h expected 0/0", dut_bus1, dut_bus2);
        end
        reset = 1'b0; delete_tagged = 1'b0;
        #1;
        model_eval();
        tests++;
        if (grant !== 4'b0011) begin
            fails++; $display("FAIL midreset_first: got %b expected %b", grant, 4'b0011);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        int              waited [NREQ];
        do_reset();
        pend = '0;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]    = 1'b1;
                    req_tag[i] = ($urandom_range(0, 3) == 0);
                    rand_payload(i);
                    if ($urandom_range(0, 7) == 0) req_rrn[i] = '0;
                    waited[i]  = 0;
                end
            end
            req           = pend;
            delete_tagged = ($urandom_range(0, 3) == 0);
            #1;
            model_eval();
            tests++;
            if (grant !== e_grant) begin
                fails++; $display("FAIL rand_grant cyc%0d: got %b expected %b", cyc, grant, e_grant);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && !req_tag[i]) begin
                    waited[i]++;
                    tests++;
                    if (!grant[i] && waited[i] >= 2) begin
                        fails++; $display("FAIL rand_fairness unit%0d: waited %0d cycles, limit 2", i, waited[i]);
                    end
                end
            end
            tick();
            tests++;
            if (dut_bus1 !== e_bus[0] || dut_bus2 !== e_bus[1]) begin
                fails++; $display("FAIL rand_bus cyc%0d: got %h/%h expected %h/%h",
                                  cyc, dut_bus1, dut_bus2, e_bus[0], e_bus[1]);
            end
            pend = pend & ~e_grant;
        end
        req = '0; delete_tagged = 1'b0;
    endtask

    initial begin
        reset = 1'b1; delete_tagged = 1'b0; req = '0; req_tag = '0;
        req_arn = '0; req_rrn = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_all_req();
        test_single();
        test_wrap();
        test_delete_tagged();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
